// File: rtl/multi_reg_pkg.sv
// Shared types, register indices and helpers for the LDM/STM/PUSH/POP sequencer.
package multi_reg_pkg;

    typedef enum logic [1:0] {
        OP_LDM  = 2'd0,
        OP_STM  = 2'd1,
        OP_PUSH = 2'd2,
        OP_POP  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StWb,
        StDone
    } state_e;

    localparam int unsigned SP_IDX     = 13;
    localparam int unsigned LR_IDX     = 14;
    localparam int unsigned PC_IDX     = 15;
    localparam int unsigned WORD_BYTES = 4;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 9; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Lowest-set-bit priority encoder over a 9-bit register list.
module lsb_priority_enc (
    input  logic [8:0] list_i,
    output logic [3:0] idx_o,
    output logic       valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        // Scan downwards so the lowest set bit wins.
        for (int i = 8; i >= 0; i--) begin
            if (list_i[i]) begin
                idx_o   = 4'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_reg_sequencer.sv
// Multi-register transfer sequencer (LDM/STM/PUSH/POP) driving the register file and memory.
// Optional misaligned-base abort is enabled by MULTI_REG_ALIGN_CHECK_EN.
module multi_reg_sequencer
    import multi_reg_pkg::*;
#(
    parameter int unsigned DATA_N = 32,
    parameter int unsigned SIZE   = 16,
    parameter int unsigned ADDR_N = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [8:0]              reg_list,
    input  logic [$clog2(SIZE)-1:0] base_idx,
    input  logic [DATA_N-1:0]       base_val,
    output logic [$clog2(SIZE)-1:0] read_addr,
    input  logic [DATA_N-1:0]       r2_data,
    output logic [ADDR_N-1:0]       mem_addr,
    output logic [DATA_N-1:0]       mem_wdata,
    output logic                    mem_we,
    output logic                    mem_re,
    input  logic [DATA_N-1:0]       mem_rdata,
    input  logic                    mem_ready,
    output logic [$clog2(SIZE)-1:0] w_addr,
    output logic [DATA_N-1:0]       w_data,
    output logic                    wr_en,
    output logic                    busy,
    output logic                    done,
    output logic                    align_fault
);

    localparam int unsigned IW = $clog2(SIZE);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [8:0]        list_q, list_d;
    logic [IW-1:0]     base_q, base_d;
    logic [ADDR_N-1:0] cur_q, cur_d, final_q, final_d;
    logic              wb_en_q, wb_en_d;
    logic              fault_q, fault_d;

    op_e               op_in;
    logic              push_pop_in;
    logic [8:0]        eff_list;
    logic [3:0]        n_regs;
    logic [ADDR_N-1:0] base_addr, span, xfer_addr;
    logic              ldm_self, misaligned, store_op;
    logic [3:0]        enc_idx;
    logic              enc_valid;
    logic [IW-1:0]     cur_idx;

    assign op_in       = op_e'(op);
    assign push_pop_in = (op_in == OP_PUSH) || (op_in == OP_POP);
    assign eff_list    = push_pop_in ? reg_list : {1'b0, reg_list[7:0]};
    assign n_regs      = popcount9(eff_list);
    assign base_addr   = ADDR_N'(base_val);
    assign span        = ADDR_N'(n_regs) * ADDR_N'(WORD_BYTES);
    // LDM that reloads its own base keeps the loaded value instead of the writeback.
    assign ldm_self    = (op_in == OP_LDM) && (base_idx < IW'(8)) && reg_list[base_idx[2:0]];
    assign store_op    = (op_q == OP_STM) || (op_q == OP_PUSH);

`ifdef MULTI_REG_ALIGN_CHECK_EN
    assign misaligned = |base_val[1:0];
    assign xfer_addr  = cur_q;
`else
    assign misaligned = 1'b0;
    assign xfer_addr  = {cur_q[ADDR_N-1:2], 2'b00};
`endif

    lsb_priority_enc u_enc (
        .list_i  (list_q),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_comb begin
        if (enc_idx == 4'd8) begin
            cur_idx = (op_q == OP_PUSH) ? IW'(LR_IDX) : IW'(PC_IDX);
        end else begin
            cur_idx = IW'(enc_idx);
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        list_d  = list_q;
        base_d  = base_q;
        cur_d   = cur_q;
        final_d = final_q;
        wb_en_d = wb_en_q;
        fault_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = StDone;
                    end else if (n_regs == 4'd0) begin
                        state_d = StDone;
                    end else begin
                        op_d    = op_in;
                        list_d  = eff_list;
                        base_d  = push_pop_in ? IW'(SP_IDX) : base_idx;
                        cur_d   = (op_in == OP_PUSH) ? base_addr - span : base_addr;
                        final_d = (op_in == OP_PUSH) ? base_addr - span : base_addr + span;
                        wb_en_d = !ldm_self;
                        state_d = StXfer;
                    end
                end
            end
            StXfer: begin
                if (mem_ready && enc_valid) begin
                    list_d = list_q & (list_q - 9'd1);
                    cur_d  = cur_q + ADDR_N'(WORD_BYTES);
                    if ((list_q & (list_q - 9'd1)) == 9'd0) begin
                        state_d = StWb;
                    end
                end
            end
            StWb:    state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        read_addr   = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        w_addr      = '0;
        w_data      = '0;
        wr_en       = 1'b0;
        busy        = (state_q == StXfer) || (state_q == StWb);
        done        = (state_q == StDone);
        align_fault = fault_q;
        if (state_q == StXfer) begin
            mem_addr  = xfer_addr;
            read_addr = cur_idx;
            if (store_op) begin
                mem_we    = 1'b1;
                mem_wdata = r2_data;
            end else begin
                mem_re = 1'b1;
                if (mem_ready) begin
                    wr_en  = 1'b1;
                    w_addr = cur_idx;
                    w_data = mem_rdata;
                end
            end
        end else if ((state_q == StWb) && wb_en_q) begin
            wr_en  = 1'b1;
            w_addr = base_q;
            w_data = DATA_N'(final_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            op_q    <= OP_LDM;
            list_q  <= '0;
            base_q  <= '0;
            cur_q   <= '0;
            final_q <= '0;
            wb_en_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            list_q  <= list_d;
            base_q  <= base_d;
            cur_q   <= cur_d;
            final_q <= final_d;
            wb_en_q <= wb_en_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_multi_reg_sequencer.sv
// Self-checking bench: register file and memory models plus a list-walk reference model.
module tb_multi_reg_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [8:0]  reg_list = '0;
    logic [3:0]  base_idx = '0;
    logic [31:0] base_val = '0;
    logic [3:0]  read_addr;
    logic [31:0] r2_data;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic        mem_ready = 1'b0;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic        wr_en, busy, done, align_fault;

    logic [31:0] rf  [16];
    logic [31:0] mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign r2_data   = rf[read_addr];
    assign mem_rdata = mem[mem_addr[9:2]];

    multi_reg_sequencer #(
        .DATA_N (32),
        .SIZE   (16),
        .ADDR_N (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .reg_list    (reg_list),
        .base_idx    (base_idx),
        .base_val    (base_val),
        .read_addr   (read_addr),
        .r2_data     (r2_data),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .wr_en       (wr_en),
        .busy        (busy),
        .done        (done),
        .align_fault (align_fault)
    );

    // Issue one instruction and compare the resulting machine state with the model.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [8:0] l,
                          input logic [3:0] bi, input int stall_pct);
        logic [31:0] erf [16];
        logic [31:0] emem [256];
        logic [31:0] eaddr [$];
        logic [8:0]  eff;
        logic [31:0] bv, sa, fin, a, prev_addr;
        logic [3:0]  prev_ra;
        logic        fault_exp, got_done, prev_req, prev_we, prev_re;
        int n, b, k, r, exp_beats, beats, done_cyc, last_beat, faults, bad, exp_done;

        eff = (o >= 2'd2) ? l : {1'b0, l[7:0]};
        n   = $countones(eff);
        b   = (o >= 2'd2) ? 13 : int'(bi);
        bv  = rf[b];
        erf  = rf;
        emem = mem;
`ifdef MULTI_REG_ALIGN_CHECK_EN
        fault_exp = (bv[1:0] != 2'b00);
`else
        fault_exp = 1'b0;
`endif
        exp_beats = (fault_exp || n == 0) ? 0 : n;
        if (exp_beats > 0) begin
            sa  = (o == 2'd2) ? bv - 32'(4 * n) : bv;
            fin = (o == 2'd2) ? bv - 32'(4 * n) : bv + 32'(4 * n);
            k = 0;
            for (int i = 0; i < 9; i++) begin
                if (eff[i]) begin
                    r = (i == 8) ? ((o == 2'd2) ? 14 : 15) : i;
                    a = (sa + 32'(4 * k)) & 32'hFFFF_FFFC;
                    eaddr.push_back(a);
                    if (o == 2'd1 || o == 2'd2) emem[a[9:2]] = rf[r];
                    else                        erf[r] = mem[a[9:2]];
                    k++;
                end
            end
            if (!(o == 2'd0 && bi < 4'd8 && l[bi[2:0]])) erf[b] = fin;
        end

        @(negedge clk);
        start = 1'b1; op = o; reg_list = l; base_idx = bi; base_val = bv; mem_ready = 1'b0;
        beats = 0; done_cyc = 0; last_beat = 0; faults = 0; got_done = 1'b0; prev_req = 1'b0;
        prev_addr = '0; prev_ra = '0; prev_we = 1'b0; prev_re = 1'b0;
        for (int cyc = 1; cyc <= 300 && !got_done; cyc++) begin
            @(negedge clk);
            start = (cyc == 2) && busy;  // stray request while busy must be ignored
            mem_ready = ($urandom_range(99) >= stall_pct);
            #1;
            if (align_fault) faults++;
            if (prev_req) begin
                checks++;
                if (mem_addr !== prev_addr || read_addr !== prev_ra ||
                    mem_we !== prev_we || mem_re !== prev_re) begin
                    errors++;
                    $display("FAIL %s hold: got addr=%0h ra=%0d we=%b re=%b expected %0h %0d %b %b",
                             tag, mem_addr, read_addr, mem_we, mem_re,
                             prev_addr, prev_ra, prev_we, prev_re);
                end
            end
            if (mem_re && !mem_ready) begin
                checks++;
                if (wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_wr: got wr_en=%b expected 0", tag, wr_en);
                end
            end
            if ((mem_we || mem_re) && mem_ready) begin
                checks++;
                if (beats >= eaddr.size() || mem_addr !== eaddr[beats]) begin
                    errors++;
                    $display("FAIL %s beat%0d_addr: got %0h expected %0h", tag, beats, mem_addr,
                             (beats < eaddr.size()) ? eaddr[beats] : 32'hDEAD_BEEF);
                end
                if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                beats++;
                last_beat = cyc;
            end
            if (wr_en) rf[w_addr] = w_data;
            prev_req  = (mem_we || mem_re) && !mem_ready;
            prev_addr = mem_addr; prev_ra = read_addr; prev_we = mem_we; prev_re = mem_re;
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end
        end
        start = 1'b0;

        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL %s done_timeout: got no done expected done within 300 cycles", tag);
        end
        checks++;
        if (beats != exp_beats) begin
            errors++;
            $display("FAIL %s beats: got %0d expected %0d", tag, beats, exp_beats);
        end
        exp_done = (exp_beats == 0) ? 1 : last_beat + 2;
        checks++;
        if (done_cyc != exp_done) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_cyc, exp_done);
        end
        if (stall_pct == 0) begin
            checks++;
            if (done_cyc != ((exp_beats == 0) ? 1 : exp_beats + 2)) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", tag, done_cyc,
                         (exp_beats == 0) ? 1 : exp_beats + 2);
            end
        end
        checks++;
        if (faults != (fault_exp ? 1 : 0)) begin
            errors++;
            $display("FAIL %s align_fault: got %0d pulses expected %0d", tag, faults,
                     fault_exp ? 1 : 0);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (rf[i] !== erf[i]) begin
                if (bad == 0)
                    $display("FAIL %s regfile r%0d: got %0h expected %0h", tag, i, rf[i], erf[i]);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== emem[i]) begin
                if (bad == 0)
                    $display("FAIL %s memory @%0h: got %0h expected %0h", tag, i * 4, mem[i],
                             emem[i]);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;

        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: got done=%b busy=%b expected 0 0", tag, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({mem_addr, read_addr, w_addr, mem_we, mem_re, wr_en, busy, done, align_fault} !== '0)
        begin
            errors++;
            $display("FAIL reset_outputs: got addr=%0h ra=%0d wa=%0d we=%b re=%b wr=%b busy=%b done=%b af=%b expected all 0",
                     mem_addr, read_addr, w_addr, mem_we, mem_re, wr_en, busy, done, align_fault);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_push();
        rf[13] = 32'h100;
        run_op("push", 2'd2, 9'h105, 4'd0, 0);
        checks++;
        if (mem[8'h3D] !== rf[0] || mem[8'h3E] !== rf[2] || mem[8'h3F] !== rf[14]) begin
            errors++;
            $display("FAIL push_mem: got %0h %0h %0h expected %0h %0h %0h",
                     mem[8'h3D], mem[8'h3E], mem[8'h3F], rf[0], rf[2], rf[14]);
        end
        checks++;
        if (rf[13] !== 32'hF4) begin
            errors++;
            $display("FAIL push_sp: got %0h expected f4", rf[13]);
        end
    endtask

    task automatic test_pop();
        rf[13] = 32'hF8;
        mem[8'h3E] = 32'hAA;
        mem[8'h3F] = 32'hBB;
        run_op("pop", 2'd3, 9'h102, 4'd0, 0);
        checks++;
        if (rf[1] !== 32'hAA || rf[15] !== 32'hBB || rf[13] !== 32'h100) begin
            errors++;
            $display("FAIL pop_regs: got r1=%0h pc=%0h sp=%0h expected aa bb 100",
                     rf[1], rf[15], rf[13]);
        end
    endtask

    task automatic test_ldm_stm();
        logic [31:0] v1, v2;
        v1 = $urandom; v2 = $urandom;
        rf[3] = 32'h200;
        mem[8'h80] = v1;
        mem[8'h81] = v2;
        run_op("ldm_self", 2'd0, 9'h018, 4'd3, 0);
        checks++;
        if (rf[3] !== v1 || rf[4] !== v2) begin
            errors++;
            $display("FAIL ldm_self_regs: got r3=%0h r4=%0h expected %0h %0h", rf[3], rf[4], v1, v2);
        end
        rf[5] = 32'h40;
        run_op("stm_wb", 2'd1, 9'h001, 4'd5, 0);
        checks++;
        if (rf[5] !== 32'h44 || mem[8'h10] !== rf[0]) begin
            errors++;
            $display("FAIL stm_wb: got r5=%0h m=%0h expected 44 %0h", rf[5], mem[8'h10], rf[0]);
        end
    endtask

    task automatic test_stall();
        rf[6] = 32'h180;
        run_op("stall_stm", 2'd1, 9'h0E5, 4'd6, 70);
        rf[2] = 32'h240;
        run_op("stall_ldm", 2'd0, 9'h0D8, 4'd2, 70);
        rf[13] = 32'h2C0;
        run_op("stall_pop", 2'd3, 9'h181, 4'd0, 60);
    endtask

    task automatic test_empty();
        rf[1] = 32'h140;
        run_op("empty", 2'd0, 9'h000, 4'd1, 0);
        run_op("empty_bit8", 2'd1, 9'h100, 4'd1, 0);
    endtask

    task automatic test_reset_mid();
        rf[6] = 32'h180;
        @(negedge clk);
        start = 1'b1; op = 2'd1; reg_list = 9'h00F; base_idx = 4'd6; base_val = rf[6];
        mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({mem_addr, read_addr, w_addr, mem_we, mem_re, wr_en, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got addr=%0h ra=%0d wa=%0d we=%b re=%b wr=%b busy=%b done=%b expected all 0",
                     mem_addr, read_addr, w_addr, mem_we, mem_re, wr_en, busy, done);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (wr_en !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet: got wr=%b we=%b done=%b expected 0 0 0",
                         wr_en, mem_we, done);
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_align();
        rf[7] = 32'h102;
        run_op("align", 2'd0, 9'h002, 4'd7, 0);
        checks++;
`ifdef MULTI_REG_ALIGN_CHECK_EN
        if (rf[7] !== 32'h102) begin
            errors++;
            $display("FAIL align_base: got %0h expected 102", rf[7]);
        end
`else
        if (rf[7] !== 32'h106) begin
            errors++;
            $display("FAIL align_base: got %0h expected 106", rf[7]);
        end
`endif
    endtask

    task automatic test_random();
        logic [1:0] o;
        logic [8:0] l;
        logic [3:0] bi;
        int b;
        for (int t = 0; t < 40; t++) begin
            o  = 2'($urandom_range(3));
            l  = ($urandom_range(9) == 0) ? 9'h000 : 9'($urandom);
            bi = 4'($urandom_range(15));
            b  = (o >= 2'd2) ? 13 : int'(bi);
            rf[b] = 32'($urandom_range(32'h40, 32'hBC)) << 2;
            run_op($sformatf("rand%0d", t), o, l, bi, int'($urandom_range(50)));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        test_reset();
        test_push();
        test_pop();
        test_ldm_stm();
        test_stall();
        test_empty();
        test_reset_mid();
        test_align();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_reg_sequencer.md
Name: multi_reg_sequencer

Overview:
- Multi-register transfer sequencer for the Thumb LDM/STM/PUSH/POP instructions.
- Sits directly upstream of the register file and owns its write port (w_addr/w_data/wr_en) and third read port (read_addr -> r2_data) while busy.
- Walks the register list one register per accepted memory beat, then writes the updated base register back.

Parameters:
- DATA_N, 32, register/data width.
- SIZE, 16, register count; index width is $clog2(SIZE).
- ADDR_N, 32, memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  0=LDM, 1=STM, 2=PUSH, 3=POP.
- reg_list  in  9  bits[7:0]=r0..r7; bit8=LR for PUSH, PC for POP, ignored for LDM/STM.
- base_idx  in  $clog2(SIZE)  Rn for LDM/STM; ignored (SP=13) for PUSH/POP.
- base_val  in  DATA_N  current Rn/SP value.
- read_addr  out  $clog2(SIZE)  register file read index.
- r2_data  in  DATA_N  register file read data.
- mem_addr  out  ADDR_N  word address.
- mem_wdata  out  DATA_N  store data.
- mem_we / mem_re  out  1  store/load request, held until mem_ready.
- mem_rdata  in  DATA_N  load data, valid with mem_ready.
- mem_ready  in  1  beat accepted this cycle.
- w_addr  out  $clog2(SIZE)  register file write index.
- w_data  out  DATA_N  register file write data.
- wr_en  out  1  register file write enable.
- busy  out  1  high in XFER and WB.
- done  out  1  one-cycle completion pulse.
- align_fault  out  1  one-cycle fault pulse; see Optional Feature.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE. All outputs 0; mem_addr=0, read_addr=0, w_addr=0.
- Reset mid-operation: abort immediately. No further mem or register writes; already-completed beats are not undone.
- States are IDLE, XFER, WB and DONE.
- IDLE, start=1, n=popcount(effective list)>0:
  - Latch op, list, base_idx.
  - cur_addr = base_val - 4n for PUSH, else base_val.
  - final_addr = base_val - 4n for PUSH, base_val + 4n otherwise.
  - Next state XFER.
- IDLE, start=1, n=0: no transfer, no writeback. Go to DONE; done pulses the following cycle.
- start while not IDLE is ignored.
- XFER: idx = lowest set bit of the remaining list; list bit8 maps to 14 (PUSH) or 15 (POP). Outputs are combinational from registered state:
  - mem_addr = cur_addr.
  - read_addr = idx.
  - Store ops: mem_we=1, mem_wdata=r2_data.
  - Load ops: mem_re=1; on mem_ready, wr_en=1, w_addr=idx, w_data=mem_rdata in the same cycle.
- On mem_ready: clear the list bit and add 4 to cur_addr. If the list becomes empty, go to WB; otherwise stay in XFER. Without mem_ready, hold all outputs.
- Ascending order, lowest register at lowest address, for all ops.
- WB: one cycle. wr_en=1, w_addr=base (13 for PUSH/POP), w_data=final_addr.
  - LDM with Rn in the list: writeback suppressed (wr_en=0) and the loaded value is kept.
  - STM with Rn in the list stores the original value, because the read happens before WB.
- WB -> DONE. DONE: done=1, busy=0 -> IDLE.
- Latency: total cycles = 1 (accept) + Σ beats + 1 (WB) + 1 (DONE).
- Arithmetic: all address arithmetic is modulo 2^ADDR_N (wrap silently).
- At most one register file write per cycle; load writes and WB never coincide.

Optional Feature:
- Macro MULTI_REG_ALIGN_CHECK_EN.
- Defined: at start, if base_val[1:0]!=0, then align_fault=1 for one cycle and the FSM goes IDLE -> DONE with zero transfers and no writeback.
- Undefined: align_fault tied 0; mem_addr[1:0] forced to 00; the transfer proceeds.

Decomposition:
- Package multi_reg_pkg:
  - op enum (OP_LDM, OP_STM, OP_PUSH, OP_POP) and state enum.
  - Constants SP_IDX=13, LR_IDX=14, PC_IDX=15, WORD_BYTES=4.
  - popcount9 function.
- Sub-module lsb_priority_enc: 9-bit input -> index plus valid, used for idx selection.

Test Plan:
- PUSH {r0,r2,LR}, SP=0x100, mem_ready=1: stores r0@0xF4, r2@0xF8, r14@0xFC; WB SP=0xF4; done on cycle 6.
- POP {r1,PC}, SP=0xF8, mem_rdata 0xAA then 0xBB: r1=0xAA, r15=0xBB, SP=0x100.
- LDM r3!,{r3,r4}, r3=0x200: r3 and r4 loaded; no WB write (r3 keeps the loaded value). STM r5!,{r0}, r5=0x40: r5=0x44.
- mem_ready low for 3 cycles mid-beat: mem_addr, we/re and read_addr held stable; no wr_en until ready; start pulse during busy ignored.
- Empty list: no mem/wr activity, done after 1 cycle. rst=0 in second XFER beat: next cycle all outputs 0, no WB.
- With MULTI_REG_ALIGN_CHECK_EN, base_val=0x102: align_fault pulse, no transfers. Without it: first mem_addr=0x100.
